dual_mult_18x18: RTL and testbench

- Two independent signed/unsigned multiplier lanes: resulta = ax*ay and resultb = bx*by.
- Configurable pipeline latency of 2 to 4 clocks.
- Portable RTL model of a DSP-block "two 18x18 full" mode, used wherever a design needs a pair of registered 18-bit products with fixed latency.

---
 rtl/dual_mult_pkg.sv | 21 ++
 rtl/dual_mult_18x18_if.sv | 20 ++
 rtl/dual_mult_18x18_mult_lane.sv | 66 ++++++
 rtl/dual_mult_18x18.sv | 48 ++++
 tb/tb_dual_mult_18x18.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dual_mult_pkg.sv
// Shared constants and operand-extension helper for the dual 18x18 multiplier.
package dual_mult_pkg;

  localparam int LAT_MIN    = 2;
  localparam int LAT_MAX    = 4;
  localparam int OPND_MAX_W = 18;
  localparam int PROD_W     = 38;

  // Widen a w-bit operand (right-justified in v) to 19 bits, sign- or zero-extending.
  function automatic logic signed [18:0] ext19(input logic [OPND_MAX_W-1:0] v,
                                               input int w, input bit sgn);
    logic [18:0] z;
    logic [18:0] mask;
    logic        s;
    z    = {1'b0, v};
    mask = ~(19'h7FFFF << w);
    s    = sgn && (((z >> (w - 1)) & 19'd1) != 19'd0);
    return s ? (z | ~mask) : (z & mask);
  endfunction

endpackage

// File: rtl/dual_mult_18x18_if.sv
// Operand/result bundle for dual_mult_18x18; clock and reset stay plain ports.
interface dual_mult_18x18_if #(
  parameter int AX_WIDTH       = 18,
  parameter int AY_WIDTH       = 18,
  parameter int BX_WIDTH       = 18,
  parameter int BY_WIDTH       = 18,
  parameter int RESULT_A_WIDTH = 36,
  parameter int RESULT_B_WIDTH = 36
) ();
  logic                      ena;
  logic [AX_WIDTH-1:0]       ax;
  logic [AY_WIDTH-1:0]       ay;
  logic [BX_WIDTH-1:0]       bx;
  logic [BY_WIDTH-1:0]       by;
  logic [RESULT_A_WIDTH-1:0] resulta;
  logic [RESULT_B_WIDTH-1:0] resultb;

  modport master (output ena, ax, ay, bx, by, input  resulta, resultb);
  modport slave  (input  ena, ax, ay, bx, by, output resulta, resultb);
endinterface

// File: rtl/dual_mult_18x18_mult_lane.sv
// One multiplier lane: S0 input reg, optional S1/S2 pipeline regs, S3 output reg.
module mult_lane
  import dual_mult_pkg::*;
#(
  parameter int XW      = 18,
  parameter int YW      = 18,
  parameter int RW      = 36,
  parameter bit SX      = 1'b1,
  parameter bit SY      = 1'b1,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          ena,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [RW-1:0] result
);

  logic signed [18:0]       x0, y0, x1, y1;
  logic signed [PROD_W-1:0] prod, prod2;

  // Operands are widened on capture so the multiplier always sees 19-bit signed values.
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      x0 <= '0;
      y0 <= '0;
    end else if (ena) begin
      x0 <= ext19(OPND_MAX_W'(x), XW, SX);
      y0 <= ext19(OPND_MAX_W'(y), YW, SY);
    end

  generate
    if (LATENCY >= 3) begin : g_s1
      always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
          x1 <= '0;
          y1 <= '0;
        end else if (ena) begin
          x1 <= x0;
          y1 <= y0;
        end
    end else begin : g_no_s1
      assign x1 = x0;
      assign y1 = y0;
    end
  endgenerate

  assign prod = x1 * y1;

  generate
    if (LATENCY == 4) begin : g_s2
      always_ff @(posedge clk or negedge clr_n)
        if (!clr_n)   prod2 <= '0;
        else if (ena) prod2 <= prod;
    end else begin : g_no_s2
      assign prod2 = prod;
    end
  endgenerate

  // Signed cast truncates narrow results and sign-extends wide ones.
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n)   result <= '0;
    else if (ena) result <= RW'(prod2);

endmodule

// File: rtl/dual_mult_18x18.sv
// Two independent fixed-latency 18x18 multiplier lanes (DSP "two 18x18 full" mode).
module dual_mult_18x18
  import dual_mult_pkg::*;
#(
  parameter int LATENCY        = 4,
  parameter int AX_WIDTH       = 18,
  parameter int AY_WIDTH       = 18,
  parameter int BX_WIDTH       = 18,
  parameter int BY_WIDTH       = 18,
  parameter int RESULT_A_WIDTH = 36,
  parameter int RESULT_B_WIDTH = 36,
  parameter bit SIGNED_X       = 1'b1,
  parameter bit SIGNED_Y       = 1'b1
) (
  input logic              clk,
  input logic              clr_n,
  dual_mult_18x18_if.slave bus
);

  generate
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
      $fatal(1, "dual_mult_18x18: LATENCY %0d outside %0d..%0d", LATENCY, LAT_MIN, LAT_MAX);
    end
    if (AX_WIDTH < 1 || AX_WIDTH > OPND_MAX_W || AY_WIDTH < 1 || AY_WIDTH > OPND_MAX_W ||
        BX_WIDTH < 1 || BX_WIDTH > OPND_MAX_W || BY_WIDTH < 1 || BY_WIDTH > OPND_MAX_W) begin : g_bad_w
      $fatal(1, "dual_mult_18x18: operand width outside 1..%0d", OPND_MAX_W);
    end
    if (RESULT_A_WIDTH < 1 || RESULT_A_WIDTH > 64 ||
        RESULT_B_WIDTH < 1 || RESULT_B_WIDTH > 64) begin : g_bad_rw
      $fatal(1, "dual_mult_18x18: result width outside 1..64");
    end
  endgenerate

  mult_lane #(
    .XW(AX_WIDTH), .YW(AY_WIDTH), .RW(RESULT_A_WIDTH),
    .SX(SIGNED_X), .SY(SIGNED_Y), .LATENCY(LATENCY)
  ) u_lane_a (
    .clk, .clr_n, .ena(bus.ena), .x(bus.ax), .y(bus.ay), .result(bus.resulta)
  );

  mult_lane #(
    .XW(BX_WIDTH), .YW(BY_WIDTH), .RW(RESULT_B_WIDTH),
    .SX(SIGNED_X), .SY(SIGNED_Y), .LATENCY(LATENCY)
  ) u_lane_b (
    .clk, .clr_n, .ena(bus.ena), .x(bus.bx), .y(bus.by), .result(bus.resultb)
  );

endmodule

// File: tb/tb_dual_mult_18x18.sv
// Five DUT configurations driven by shared operands, checked against a queue-based product model.
module tb_dual_mult_18x18;

  localparam int ND = 5;
  // d0: L4 signed, d1: L3 signed, d2: L2 signed, d3: L4 unsigned, d4: L4 signed, resulta 16 bits
  localparam int LAT [ND] = '{4, 3, 2, 4, 4};
  localparam bit SGN [ND] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam int RWA [ND] = '{36, 36, 36, 36, 16};

  logic        clk = 1'b0;
  logic        clr_n;
  logic        ena;
  logic [17:0] ax, ay, bx, by;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  dual_mult_18x18_if #(.RESULT_A_WIDTH(36)) i0 ();
  dual_mult_18x18_if #(.RESULT_A_WIDTH(36)) i1 ();
  dual_mult_18x18_if #(.RESULT_A_WIDTH(36)) i2 ();
  dual_mult_18x18_if #(.RESULT_A_WIDTH(36)) i3 ();
  dual_mult_18x18_if #(.RESULT_A_WIDTH(16)) i4 ();

  dual_mult_18x18 #(.LATENCY(4)) u_d0 (.clk(clk), .clr_n(clr_n), .bus(i0));
  dual_mult_18x18 #(.LATENCY(3)) u_d1 (.clk(clk), .clr_n(clr_n), .bus(i1));
  dual_mult_18x18 #(.LATENCY(2)) u_d2 (.clk(clk), .clr_n(clr_n), .bus(i2));
  dual_mult_18x18 #(.LATENCY(4), .SIGNED_X(1'b0), .SIGNED_Y(1'b0)) u_d3 (.clk(clk), .clr_n(clr_n), .bus(i3));
  dual_mult_18x18 #(.LATENCY(4), .RESULT_A_WIDTH(16)) u_d4 (.clk(clk), .clr_n(clr_n), .bus(i4));

  assign {i0.ena, i0.ax, i0.ay, i0.bx, i0.by} = {ena, ax, ay, bx, by};
  assign {i1.ena, i1.ax, i1.ay, i1.bx, i1.by} = {ena, ax, ay, bx, by};
  assign {i2.ena, i2.ax, i2.ay, i2.bx, i2.by} = {ena, ax, ay, bx, by};
  assign {i3.ena, i3.ax, i3.ay, i3.bx, i3.by} = {ena, ax, ay, bx, by};
  assign {i4.ena, i4.ax, i4.ay, i4.bx, i4.by} = {ena, ax, ay, bx, by};

  logic [63:0] ra [ND];
  logic [63:0] rb [ND];
  assign ra[0] = 64'(i0.resulta); assign rb[0] = 64'(i0.resultb);
  assign ra[1] = 64'(i1.resulta); assign rb[1] = 64'(i1.resultb);
  assign ra[2] = 64'(i2.resulta); assign rb[2] = 64'(i2.resultb);
  assign ra[3] = 64'(i3.resulta); assign rb[3] = 64'(i3.resultb);
  assign ra[4] = 64'(i4.resulta); assign rb[4] = 64'(i4.resultb);

  // Products of captured operands, oldest first; the output is the one LATENCY-1 enabled edges old.
  longint unsigned qa [ND][$];
  longint unsigned qb [ND][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned mdl(input logic [17:0] x, input logic [17:0] y,
                                          input bit sgn, input int rw);
    longint xs, ys, p;
    xs = (sgn && x[17]) ? longint'(x) - 64'sd262144 : longint'(x);
    ys = (sgn && y[17]) ? longint'(y) - 64'sd262144 : longint'(y);
    p  = xs * ys;
    return (rw >= 64) ? longint'(p) : (p & ((64'sd1 <<< rw) - 64'sd1));
  endfunction

  function automatic longint unsigned expect_of(input longint unsigned q[$], input int l);
    return (q.size() == l) ? q[0] : 64'd0;
  endfunction

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s_d%0d_a", tag, d), ra[d], expect_of(qa[d], LAT[d]));
      chk($sformatf("%s_d%0d_b", tag, d), rb[d], expect_of(qb[d], LAT[d]));
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      qa[d].delete();
      qb[d].delete();
    end
  endtask

  // One clock: update the model with what the DUTs capture at this edge, then check.
  task automatic step(input string tag);
    @(posedge clk);
    if (!clr_n) clear_model();
    else if (ena) begin
      for (int d = 0; d < ND; d++) begin
        qa[d].push_back(mdl(ax, ay, SGN[d], RWA[d]));
        qb[d].push_back(mdl(bx, by, SGN[d], 36));
        if (qa[d].size() > LAT[d]) void'(qa[d].pop_front());
        if (qb[d].size() > LAT[d]) void'(qb[d].pop_front());
      end
    end
    #2;
    check_all(tag);
  endtask

  task automatic drive(input logic [17:0] a0, input logic [17:0] a1,
                       input logic [17:0] b0, input logic [17:0] b1);
    ax = a0; ay = a1; bx = b0; by = b1;
  endtask

  initial begin
    clr_n = 1'b0;
    ena   = 1'b1;
    drive('0, '0, '0, '0);
    clear_model();
    #3;
    check_all("reset");
    step("reset_edge");
    #1 clr_n = 1'b1;
    step("idle");

    // Basic signed product, then zeros
    drive(18'd3, 18'h3FFFC, 18'd100, 18'd200);
    step("basic");
    drive('0, '0, '0, '0);
    step("basic");
    step("basic");
    step("basic");
    chk("basic_a_lat4", ra[0], 64'hF_FFFF_FFF4);
    chk("basic_b_lat4", rb[0], 64'd20000);
    step("basic");
    chk("basic_a_after", ra[0], 64'd0);

    // Signed extremes
    drive(18'h20000, 18'h20000, 18'h20000, 18'h1FFFF);
    step("extreme");
    drive('0, '0, '0, '0);
    step("extreme");
    step("extreme");
    step("extreme");
    chk("extreme_a_lat4", ra[0], 64'h4_0000_0000);
    chk("extreme_b_lat4", rb[0], 64'hC_0002_0000);
    step("extreme");

    // Unsigned and truncating configurations
    drive(18'h3FFFF, 18'd2, 18'd300, 18'd300);
    step("uns");
    drive(18'd300, 18'd300, '0, '0);
    step("uns");
    drive('0, '0, '0, '0);
    step("uns");
    step("uns");
    chk("unsigned_a", ra[3], 64'd524286);
    step("uns");
    chk("trunc16_a", ra[4], 64'd24464);
    step("uns");

    // Streaming with an enable stall in the middle
    for (int i = 0; i < 16; i++) begin
      drive(18'(i), 18'(i + 1), 18'(i + 3), 18'h3FFFF - 18'(i));
      if (i == 8) begin
        ena = 1'b0;
        for (int k = 0; k < 3; k++) step("stall");
        ena = 1'b1;
      end
      step("stream");
    end
    drive('0, '0, '0, '0);
    for (int k = 0; k < 4; k++) step("drain");

    // Reset between edges discards in-flight products
    drive(18'd1234, 18'd5678, 18'h2ABCD, 18'd77);
    step("pre_rst");
    step("pre_rst");
    #1 clr_n = 1'b0;
    clear_model();
    #1;
    check_all("async_rst");
    step("in_rst");
    #1 clr_n = 1'b1;
    drive('0, '0, '0, '0);
    for (int k = 0; k < 4; k++) step("post_rst");

    // Random operands with random enable
    for (int n = 0; n < 300; n++) begin
      drive(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
      ena = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
